sdio_evt_sync: RTL

Parametrised, multi-channel receive-side event synchroniser for the SDIO core. It is clocked only by the destination clock. Each channel carries an asynchronous signal from the other clock domain, either as a toggle-encoded event or as a level. Toggle channels get a programmable-depth synchroniser, edge-to-pulse conversion and a per-channel saturating pending-event counter with pop handshake and sticky overflow. Level channels get the synchroniser and an optional glitch filter. The block replaces per-signal fixed 2/3-flop syncs in sys_clk or sd_clk consumers, where bursts of events must not be lost while the consumer is busy.

---
 rtl/sdio_sync_pkg.sv | 17 +
 rtl/sdio_evt_chan.sv | 127 ++++++++++++
 rtl/sdio_evt_sync.sv | 49 ++++
 3 files changed

// File: rtl/sdio_sync_pkg.sv
// Shared constants for the SDIO receive-side event synchroniser.
// Optional level-channel glitch filter is enabled with SDIO_EVT_FILT_EN.
package sdio_sync_pkg;

    localparam logic SDIO_CH_TOGGLE = 1'b1;
    localparam logic SDIO_CH_LEVEL  = 1'b0;

    localparam int SYNC_MAX     = 4;
    localparam int CNT_W_MAX    = 8;
    localparam int FILT_LEN_DEF = 3;

    // Saturation value of a pending counter of the given width.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sdio_evt_chan.sv
// One synchroniser channel: toggle/event path with pending counter, or level path.
// Level path adds a glitch filter when SDIO_EVT_FILT_EN is defined.
module sdio_evt_chan
    import sdio_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic MODE        = SDIO_CH_TOGGLE,
    parameter int   CNT_W       = 4,
    parameter int   FILT_LEN    = FILT_LEN_DEF
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             sys_rst,
    input  logic             async_in,
    input  logic             evt_pop,
    input  logic             ovf_clr,
    output logic             evt_pulse,
    output logic             evt_pend,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             evt_ovf,
    output logic             lvl_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   smp;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else if (sys_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign smp = sync_q[SYNC_STAGES-1];

    generate
        if (MODE == SDIO_CH_TOGGLE) begin : g_tog
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

            logic             prev_q;
            logic [CNT_W-1:0] cnt_q;
            logic             ovf_q;
            logic             inc;
            logic             pop;
            logic             sat;

            assign inc = smp ^ prev_q;
            // A pop against an empty counter is simply dropped.
            assign pop = evt_pop & (cnt_q != '0);
            assign sat = (cnt_q == CNT_MAX);

            always_ff @(posedge sys_clk or negedge rstn) begin
                if (!rstn) begin
                    prev_q <= 1'b0;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                end else if (sys_rst) begin
                    prev_q <= 1'b0;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    prev_q <= smp;
                    if (inc && !pop) begin
                        if (!sat) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (!inc && pop) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    // A new overflow beats a simultaneous clear.
                    if (inc && !pop && sat) begin
                        ovf_q <= 1'b1;
                    end else if (ovf_clr) begin
                        ovf_q <= 1'b0;
                    end
                end
            end

            assign evt_pulse = inc;
            assign evt_pend  = (cnt_q != '0);
            assign evt_cnt   = cnt_q;
            assign evt_ovf   = ovf_q;
            assign lvl_out   = 1'b0;
        end else begin : g_lvl
            logic unused_lvl_in;

            assign unused_lvl_in = evt_pop ^ ovf_clr;
            assign evt_pulse     = 1'b0;
            assign evt_pend      = 1'b0;
            assign evt_cnt       = '0;
            assign evt_ovf       = 1'b0;

`ifdef SDIO_EVT_FILT_EN
            localparam int FW = $clog2(FILT_LEN + 1);

            logic [FW-1:0] run_q;
            logic          lvl_q;

            // lvl_q only moves after smp has disagreed for FILT_LEN consecutive edges.
            always_ff @(posedge sys_clk or negedge rstn) begin
                if (!rstn) begin
                    run_q <= '0;
                    lvl_q <= 1'b0;
                end else if (sys_rst) begin
                    run_q <= '0;
                    lvl_q <= 1'b0;
                end else if (smp == lvl_q) begin
                    run_q <= '0;
                end else if (run_q == FW'(FILT_LEN - 1)) begin
                    run_q <= '0;
                    lvl_q <= smp;
                end else begin
                    run_q <= run_q + 1'b1;
                end
            end

            assign lvl_out = lvl_q;
`else
            assign lvl_out = smp;
`endif
        end
    endgenerate

endmodule

// File: rtl/sdio_evt_sync.sv
// Multi-channel destination-clock event/level synchroniser for the SDIO core.
// Define SDIO_EVT_FILT_EN to add the glitch filter on level channels.
module sdio_evt_sync
    import sdio_sync_pkg::*;
#(
    parameter int             NCH         = 8,
    parameter int             SYNC_STAGES = 2,
    parameter logic [NCH-1:0] CHAN_MODE   = '1,
    parameter int             CNT_W       = 4,
    parameter int             FILT_LEN    = FILT_LEN_DEF
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 sys_rst,
    input  logic [NCH-1:0]       async_in,
    output logic [NCH-1:0]       evt_pulse,
    output logic [NCH-1:0]       evt_pend,
    output logic [NCH*CNT_W-1:0] evt_cnt,
    input  logic [NCH-1:0]       evt_pop,
    output logic [NCH-1:0]       evt_ovf,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH-1:0]       lvl_out
);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_chan
            sdio_evt_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .MODE        (CHAN_MODE[i]),
                .CNT_W       (CNT_W),
                .FILT_LEN    (FILT_LEN)
            ) u_chan (
                .sys_clk   (sys_clk),
                .rstn      (rstn),
                .sys_rst   (sys_rst),
                .async_in  (async_in[i]),
                .evt_pop   (evt_pop[i]),
                .ovf_clr   (ovf_clr[i]),
                .evt_pulse (evt_pulse[i]),
                .evt_pend  (evt_pend[i]),
                .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W]),
                .evt_ovf   (evt_ovf[i]),
                .lvl_out   (lvl_out[i])
            );
        end
    endgenerate

endmodule
